pci_initiator: RTL and testbench

- Single-data-phase PCI bus master; the requester side of the bus our target block answers.
- Accepts one local request (IO/memory/config read or write, one DWORD), arbitrates with REQ#/GNT#, and runs the address and data phases.
- Returns read data and a completion status.
- Uses split-tristate pad convention: *_I inputs, *_O outputs, OE_*_N enables. Used by the board bring-up path to ping targets on the same bus.

---
 rtl/pci_pkg.sv | 32 +++
 rtl/pci_parity.sv | 11 +
 rtl/pci_initiator.sv | 241 ++++++++++++++++++++++++
 tb/tb_pci_initiator.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pci_pkg.sv
// PCI shared definitions: bus commands, completion status, initiator states.
// Imported by the initiator and the target block.
package pci_pkg;

    localparam logic [3:0] CMD_IO_RD  = 4'b0010;
    localparam logic [3:0] CMD_IO_WR  = 4'b0011;
    localparam logic [3:0] CMD_MEM_RD = 4'b0110;
    localparam logic [3:0] CMD_MEM_WR = 4'b0111;
    localparam logic [3:0] CMD_CFG_RD = 4'b1010;
    localparam logic [3:0] CMD_CFG_WR = 4'b1011;

    typedef enum logic [1:0] {
        ST_OK     = 2'b00,
        ST_MABORT = 2'b01,
        ST_TABORT = 2'b10,
        ST_RETRY  = 2'b11
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_ADDR,
        S_DATA,
        S_TURN
    } state_e;

    // Every write command has bit 0 set.
    function automatic logic cmd_is_write(logic [3:0] cmd);
        return cmd[0];
    endfunction

endpackage

// File: rtl/pci_parity.sv
// Even parity over one PCI phase (AD and C/BE#).
// Pure combinational, shared with the target block.
module pci_parity (
    input  logic [31:0] ad,
    input  logic [3:0]  cbe,
    output logic        par
);

    assign par = ^{ad, cbe};

endmodule

// File: rtl/pci_initiator.sv
// Single-data-phase PCI bus master with split tristate pads.
// One local request in, one DONE pulse with status/read data out.
module pci_initiator
    import pci_pkg::*;
#(
    parameter int DEVSEL_TIMEOUT = 5,
    parameter int RETRY_LIMIT    = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic [3:0]  REQ_CMD,
    input  logic [31:0] REQ_ADDR,
    input  logic [31:0] REQ_WDATA,
    input  logic [3:0]  REQ_BE_N,
    output logic        DONE,
    output logic [31:0] RDATA,
    output logic [1:0]  STATUS,
    input  logic [31:0] AD_I,
    output logic [31:0] AD_O,
    output logic        OE_AD_N,
    output logic [3:0]  CBE_O_N,
    output logic        OE_CBE_N,
    input  logic        PAR_I,
    output logic        PAR_O,
    output logic        OE_PAR_N,
    input  logic        FRAME_I_N,
    output logic        FRAME_O_N,
    output logic        OE_FRAME_N,
    input  logic        IRDY_I_N,
    output logic        IRDY_O_N,
    output logic        OE_IRDY_N,
    input  logic        TRDY_I_N,
    input  logic        STOP_I_N,
    input  logic        DEVSEL_I_N,
    input  logic        GNT_I_N,
    output logic        REQ_O_N,
    output logic        OE_REQ_N
);

    localparam logic [7:0] DEV_LAST = 8'(DEVSEL_TIMEOUT - 1);
    localparam logic [7:0] RTY_MAX  = 8'(RETRY_LIMIT);

    state_e      state_q, state_n;
    logic [3:0]  cmd_q, cmd_n;
    logic [31:0] addr_q, addr_n;
    logic [31:0] wdata_q, wdata_n;
    logic [3:0]  be_q, be_n;
    logic [7:0]  rty_q, rty_n;
    logic [7:0]  dev_q, dev_n;

    logic [31:0] ad_o_n, rdata_n;
    logic [3:0]  cbe_o_n_n;
    logic [1:0]  status_n;
    logic        par_o_n, frame_o_n_n, irdy_o_n_n, req_o_n_n, done_n;
    logic        oe_ad_n_n, oe_cbe_n_n, oe_par_n_n;
    logic        oe_frame_n_n, oe_irdy_n_n, oe_req_n_n;

    logic        par;
    logic        wr;
    logic        unused_par;

    assign unused_par = PAR_I;
    assign wr         = cmd_is_write(cmd_q);
    assign REQ_READY  = (state_q == S_IDLE) && !DONE;

    // Address parity is computed in ADDR, data parity in DATA.
    pci_parity u_par (
        .ad  ((state_q == S_ADDR) ? addr_q : wdata_q),
        .cbe ((state_q == S_ADDR) ? cmd_q  : be_q),
        .par (par)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            cmd_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            rty_q      <= '0;
            dev_q      <= '0;
            AD_O       <= '0;
            CBE_O_N    <= '0;
            PAR_O      <= 1'b0;
            FRAME_O_N  <= 1'b1;
            IRDY_O_N   <= 1'b1;
            REQ_O_N    <= 1'b1;
            OE_AD_N    <= 1'b1;
            OE_CBE_N   <= 1'b1;
            OE_PAR_N   <= 1'b1;
            OE_FRAME_N <= 1'b1;
            OE_IRDY_N  <= 1'b1;
            OE_REQ_N   <= 1'b1;
            DONE       <= 1'b0;
            RDATA      <= '0;
            STATUS     <= ST_OK;
        end else begin
            state_q    <= state_n;
            cmd_q      <= cmd_n;
            addr_q     <= addr_n;
            wdata_q    <= wdata_n;
            be_q       <= be_n;
            rty_q      <= rty_n;
            dev_q      <= dev_n;
            AD_O       <= ad_o_n;
            CBE_O_N    <= cbe_o_n_n;
            PAR_O      <= par_o_n;
            FRAME_O_N  <= frame_o_n_n;
            IRDY_O_N   <= irdy_o_n_n;
            REQ_O_N    <= req_o_n_n;
            OE_AD_N    <= oe_ad_n_n;
            OE_CBE_N   <= oe_cbe_n_n;
            OE_PAR_N   <= oe_par_n_n;
            OE_FRAME_N <= oe_frame_n_n;
            OE_IRDY_N  <= oe_irdy_n_n;
            OE_REQ_N   <= oe_req_n_n;
            DONE       <= done_n;
            RDATA      <= rdata_n;
            STATUS     <= status_n;
        end
    end

    always_comb begin
        state_n      = state_q;
        cmd_n        = cmd_q;
        addr_n       = addr_q;
        wdata_n      = wdata_q;
        be_n         = be_q;
        rty_n        = rty_q;
        dev_n        = dev_q;
        ad_o_n       = AD_O;
        cbe_o_n_n    = CBE_O_N;
        par_o_n      = PAR_O;
        frame_o_n_n  = FRAME_O_N;
        irdy_o_n_n   = IRDY_O_N;
        req_o_n_n    = REQ_O_N;
        oe_ad_n_n    = OE_AD_N;
        oe_cbe_n_n   = OE_CBE_N;
        oe_par_n_n   = OE_PAR_N;
        oe_frame_n_n = OE_FRAME_N;
        oe_irdy_n_n  = OE_IRDY_N;
        oe_req_n_n   = OE_REQ_N;
        done_n       = 1'b0;
        rdata_n      = RDATA;
        status_n     = STATUS;

        unique case (state_q)
            S_IDLE: begin
                if (REQ_VALID && REQ_READY) begin
                    cmd_n      = REQ_CMD;
                    addr_n     = REQ_ADDR;
                    wdata_n    = REQ_WDATA;
                    be_n       = REQ_BE_N;
                    rty_n      = '0;
                    req_o_n_n  = 1'b0;
                    oe_req_n_n = 1'b0;
                    state_n    = S_ARB;
                end
            end
            S_ARB: begin
                if (!GNT_I_N && FRAME_I_N && IRDY_I_N) begin
                    frame_o_n_n  = 1'b0;
                    ad_o_n       = addr_q;
                    cbe_o_n_n    = cmd_q;
                    oe_frame_n_n = 1'b0;
                    oe_ad_n_n    = 1'b0;
                    oe_cbe_n_n   = 1'b0;
                    req_o_n_n    = 1'b1;
                    state_n      = S_ADDR;
                end
            end
            S_ADDR: begin
                frame_o_n_n = 1'b1;
                irdy_o_n_n  = 1'b0;
                oe_irdy_n_n = 1'b0;
                cbe_o_n_n   = be_q;
                par_o_n     = par;
                oe_par_n_n  = 1'b0;
                dev_n       = '0;
                state_n     = S_DATA;
                if (wr) begin
                    ad_o_n = wdata_q;
                end else begin
                    oe_ad_n_n = 1'b1;
                end
            end
            S_DATA: begin
                if (dev_q != 8'hFF) begin
                    dev_n = dev_q + 8'd1;
                end
                // Data parity lags the data phase by one clock.
                if (dev_q == 8'd0) begin
                    if (wr) begin
                        par_o_n = par;
                    end else begin
                        oe_par_n_n = 1'b1;
                    end
                end
                state_n = S_TURN;
                if (!DEVSEL_I_N && !TRDY_I_N) begin
                    status_n = ST_OK;
                    if (!wr) begin
                        rdata_n = AD_I;
                    end
                end else if (!DEVSEL_I_N && !STOP_I_N) begin
                    status_n = ST_RETRY;
                end else if (DEVSEL_I_N && !STOP_I_N) begin
                    status_n = ST_TABORT;
                end else if (DEVSEL_I_N && dev_q == DEV_LAST) begin
                    status_n = ST_MABORT;
                end else begin
                    state_n = S_DATA;
                end
                if (state_n == S_TURN) begin
                    irdy_o_n_n = 1'b1;
                    oe_ad_n_n  = 1'b1;
                    oe_cbe_n_n = 1'b1;
                end
            end
            S_TURN: begin
                oe_irdy_n_n  = 1'b1;
                oe_frame_n_n = 1'b1;
                oe_par_n_n   = 1'b1;
                if (STATUS == ST_RETRY && rty_q < RTY_MAX) begin
                    rty_n      = rty_q + 8'd1;
                    req_o_n_n  = 1'b0;
                    oe_req_n_n = 1'b0;
                    state_n    = S_ARB;
                end else begin
                    done_n     = 1'b1;
                    oe_req_n_n = 1'b1;
                    state_n    = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_pci_initiator.sv
// Directed bench for pci_initiator with a simple PCI target model.
// Expected completions are queued at issue time and popped on DONE.
module tb_pci_initiator;
    import pci_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        REQ_VALID = 1'b0;
    logic        REQ_READY;
    logic [3:0]  REQ_CMD = '0;
    logic [31:0] REQ_ADDR = '0;
    logic [31:0] REQ_WDATA = '0;
    logic [3:0]  REQ_BE_N = '0;
    logic        DONE;
    logic [31:0] RDATA;
    logic [1:0]  STATUS;
    logic [31:0] AD_I, AD_O;
    logic        OE_AD_N;
    logic [3:0]  CBE_O_N;
    logic        OE_CBE_N;
    logic        PAR_O, OE_PAR_N;
    logic        FRAME_I_N, FRAME_O_N, OE_FRAME_N;
    logic        IRDY_I_N, IRDY_O_N, OE_IRDY_N;
    logic        REQ_O_N, OE_REQ_N;
    logic        gnt_n = 1'b0;
    logic        other_frame_n = 1'b1;

    logic        devsel_n = 1'b1;
    logic        trdy_n = 1'b1;
    logic        stop_n = 1'b1;
    int          tgt_mode = 1;
    int          tgt_lat = 1;
    logic [31:0] tgt_rdata = '0;
    int          dclk = 0;
    int          addr_phases = 0;
    int          done_cnt = 0;
    int          irdy_cnt = 0;
    int          addrv_cnt = 0;

    typedef struct {
        logic [1:0]  st;
        logic [31:0] rd;
        logic        chk_rd;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    assign FRAME_I_N = (OE_FRAME_N ? 1'b1 : FRAME_O_N) & other_frame_n;
    assign IRDY_I_N  = OE_IRDY_N ? 1'b1 : IRDY_O_N;
    assign AD_I      = OE_AD_N ? tgt_rdata : AD_O;

    pci_initiator #(.DEVSEL_TIMEOUT(5), .RETRY_LIMIT(4)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_CMD(REQ_CMD), .REQ_ADDR(REQ_ADDR),
        .REQ_WDATA(REQ_WDATA), .REQ_BE_N(REQ_BE_N),
        .DONE(DONE), .RDATA(RDATA), .STATUS(STATUS),
        .AD_I(AD_I), .AD_O(AD_O), .OE_AD_N(OE_AD_N),
        .CBE_O_N(CBE_O_N), .OE_CBE_N(OE_CBE_N),
        .PAR_I(1'b0), .PAR_O(PAR_O), .OE_PAR_N(OE_PAR_N),
        .FRAME_I_N(FRAME_I_N), .FRAME_O_N(FRAME_O_N),
        .OE_FRAME_N(OE_FRAME_N),
        .IRDY_I_N(IRDY_I_N), .IRDY_O_N(IRDY_O_N),
        .OE_IRDY_N(OE_IRDY_N),
        .TRDY_I_N(trdy_n), .STOP_I_N(stop_n),
        .DEVSEL_I_N(devsel_n), .GNT_I_N(gnt_n),
        .REQ_O_N(REQ_O_N), .OE_REQ_N(OE_REQ_N)
    );

    // Target: responds on data clock tgt_lat according to tgt_mode.
    always @(negedge CLK) begin
        if (!FRAME_O_N && !OE_FRAME_N) begin
            addr_phases <= addr_phases + 1;
            dclk <= 0;
            devsel_n <= 1'b1;
            trdy_n <= 1'b1;
            stop_n <= 1'b1;
        end else if (!IRDY_O_N && !OE_IRDY_N) begin
            dclk <= dclk + 1;
            irdy_cnt <= irdy_cnt + 1;
            if (!OE_AD_N) addrv_cnt <= addrv_cnt + 1;
            if (dclk + 1 >= tgt_lat) begin
                devsel_n <= !(tgt_mode == 1 || tgt_mode == 2);
                trdy_n   <= !(tgt_mode == 1);
                stop_n   <= !(tgt_mode == 2 || tgt_mode == 3);
            end
        end else begin
            devsel_n <= 1'b1;
            trdy_n <= 1'b1;
            stop_n <= 1'b1;
        end
        if (DONE) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] oes();
        return {OE_AD_N, OE_CBE_N, OE_PAR_N, OE_FRAME_N, OE_IRDY_N, OE_REQ_N};
    endfunction

    task automatic issue(input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] w, input logic [3:0] be,
                         input exp_t e);
        int n = 0;
        @(negedge CLK);
        while (!REQ_READY && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("req_ready", 64'(REQ_READY), 64'd1);
        REQ_VALID = 1'b1;
        REQ_CMD   = c;
        REQ_ADDR  = a;
        REQ_WDATA = w;
        REQ_BE_N  = be;
        sb.push_back(e);
        @(posedge CLK);
        #1 REQ_VALID = 1'b0;
    endtask

    task automatic wait_frame(input string tag);
        int n = 0;
        while (!(!FRAME_O_N && !OE_FRAME_N) && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_frame"}, 64'(FRAME_O_N), 64'd0);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        exp_t e;
        while (!DONE && n < 300) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_done"}, 64'(DONE), 64'd1);
        if (DONE && sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_status"}, 64'(STATUS), 64'(e.st));
            if (e.chk_rd) chk({tag, "_rdata"}, 64'(RDATA), 64'(e.rd));
            chk({tag, "_ready_low"}, 64'(REQ_READY), 64'd0);
        end
        @(negedge CLK);
    endtask

    initial begin
        int irdy0, addrv0, ap0, dn0, n;
        exp_t e;

        #12;
        chk("rst_oe", 64'(oes()), 64'h3F);
        chk("rst_ctl", 64'({FRAME_O_N, IRDY_O_N, REQ_O_N}), 64'h7);
        chk("rst_bus", 64'({AD_O, CBE_O_N, PAR_O}), 64'h0);
        chk("rst_out", 64'({DONE, STATUS, RDATA}), 64'h0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);

        // IO write, target claims on second data clock
        tgt_mode = 1; tgt_lat = 2;
        irdy0 = irdy_cnt; addrv0 = addrv_cnt;
        e = '{st: ST_OK, rd: 32'h0, chk_rd: 1'b0};
        issue(CMD_IO_WR, 32'h10, 32'h12345678, 4'b0000, e);
        wait_frame("iow");
        chk("iow_addr", 64'(AD_O), 64'h10);
        chk("iow_cmd", 64'(CBE_O_N), 64'(CMD_IO_WR));
        @(negedge CLK);
        chk("iow_frame_1clk", 64'(FRAME_O_N), 64'd1);
        chk("iow_data", 64'({AD_O, CBE_O_N}), 64'({32'h12345678, 4'b0000}));
        chk("iow_apar", 64'({PAR_O, OE_PAR_N}),
            64'({^{32'h10, CMD_IO_WR}, 1'b0}));
        @(negedge CLK);
        chk("iow_dpar", 64'(PAR_O), 64'(^{32'h12345678, 4'b0000}));
        wait_done("iow");
        chk("iow_irdy_clks", 64'(irdy_cnt - irdy0), 64'd2);
        chk("iow_ad_driven", 64'(addrv_cnt - addrv0), 64'd2);

        // Config read
        tgt_mode = 1; tgt_lat = 1; tgt_rdata = 32'h030010EA;
        addrv0 = addrv_cnt;
        e = '{st: ST_OK, rd: 32'h030010EA, chk_rd: 1'b1};
        issue(CMD_CFG_RD, 32'h0, 32'hDEADBEEF, 4'b0000, e);
        wait_done("cfgr");
        chk("cfgr_ad_released", 64'(addrv_cnt - addrv0), 64'd0);

        // Memory read, no DEVSEL
        tgt_mode = 0; tgt_rdata = 32'h55AA55AA;
        irdy0 = irdy_cnt;
        e = '{st: ST_MABORT, rd: 32'h0, chk_rd: 1'b0};
        issue(CMD_MEM_RD, 32'h1000, 32'h0, 4'b0000, e);
        wait_done("mabort");
        chk("mabort_clks", 64'(irdy_cnt - irdy0), 64'd5);
        chk("mabort_oe", 64'(oes()), 64'h3F);

        // Retry on every attempt
        tgt_mode = 2; tgt_lat = 1;
        ap0 = addr_phases; dn0 = done_cnt;
        e = '{st: ST_RETRY, rd: 32'h0, chk_rd: 1'b0};
        issue(CMD_MEM_WR, 32'h2000, 32'hA5A5A5A5, 4'b0011, e);
        wait_done("retry");
        repeat (3) @(negedge CLK);
        chk("retry_addr_phases", 64'(addr_phases - ap0), 64'd5);
        chk("retry_done_once", 64'(done_cnt - dn0), 64'd1);

        // STOP without DEVSEL
        tgt_mode = 3;
        e = '{st: ST_TABORT, rd: 32'h0, chk_rd: 1'b0};
        issue(CMD_MEM_WR, 32'h3000, 32'h1, 4'b0000, e);
        wait_done("tabort");

        // Granted while another master owns the bus
        tgt_mode = 1; other_frame_n = 1'b0;
        e = '{st: ST_OK, rd: 32'h0, chk_rd: 1'b0};
        issue(CMD_MEM_WR, 32'h4000, 32'hCAFEF00D, 4'b1100, e);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("busy_no_frame", 64'({FRAME_O_N, REQ_O_N}), 64'b10);
        end
        other_frame_n = 1'b1;
        wait_frame("busy");
        chk("busy_addr", 64'(AD_O), 64'h4000);
        wait_done("busy");

        // Reset in the middle of a data phase
        tgt_mode = 0;
        e = '{st: ST_MABORT, rd: 32'h0, chk_rd: 1'b0};
        issue(CMD_MEM_RD, 32'h5000, 32'h0, 4'b0000, e);
        n = 0;
        while (IRDY_O_N && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("mid_in_data", 64'(IRDY_O_N), 64'd0);
        @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        chk("mid_rst_oe", 64'(oes()), 64'h3F);
        chk("mid_rst_ctl", 64'({FRAME_O_N, IRDY_O_N, REQ_O_N}), 64'h7);
        sb.delete();
        dn0 = done_cnt;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        chk("mid_no_done", 64'(done_cnt - dn0), 64'd0);
        chk("mid_ready", 64'(REQ_READY), 64'd1);

        // Normal traffic after reset
        tgt_mode = 1; tgt_lat = 1; tgt_rdata = 32'h0BADF00D;
        e = '{st: ST_OK, rd: 32'h0BADF00D, chk_rd: 1'b1};
        issue(CMD_IO_RD, 32'h20, 32'h0, 4'b0000, e);
        wait_done("post");
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
